// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Stage 1 registers bit generate/propagate and 4-bit group GG/GP terms.
// Stage 2 resolves group carries, then bit carries, and registers S/cout.
// Optional signed-overflow output is enabled by defining CLA_OVF_EN.
module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = WIDTH / 4;

    // Stage-1 state
    logic             v1;
    logic [WIDTH-1:0] g1;
    logic [WIDTH-1:0] p1;
    logic [NG-1:0]    gg1;
    logic [NG-1:0]    gp1;
    logic             c1;

    // Stage-2 valid flag
    logic v2;

    // Combinational terms
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [NG-1:0]    gg_in;
    logic [NG-1:0]    gp_in;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             load1;
    logic             load2;

    // Handshake: stage 2 advances when empty or drained; stage 1 when empty or stage 2 advances
    always_comb begin
        load2     = !v2 || out_ready;
        load1     = !v1 || load2;
        in_ready  = !v1 || !v2 || out_ready;
        out_valid = v2;
    end

    // Bit and 4-bit group generate/propagate terms from the incoming operands
    always_comb begin
        g_in  = a & b;
        p_in  = a ^ b;
        gg_in = '0;
        gp_in = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            gg_in[k] = g_in[4*k+3]
                     | (p_in[4*k+3] & g_in[4*k+2])
                     | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                     | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
            gp_in[k] = &p_in[4*k +: 4];
        end
    end

    // Group carries from registered GG/GP, then bit carries within each group.
    // Scalar running carries keep the carry vector free of self-dependencies.
    always_comb begin
        logic gcar;
        logic rc;
        carry = '0;
        gcar  = c1;
        rc    = 1'b0;
        for (int unsigned k = 0; k < NG; k++) begin
            rc = gcar;
            for (int unsigned j = 0; j < 4; j++) begin
                carry[4*k+j] = rc;
                rc = g1[4*k+j] | (p1[4*k+j] & rc);
            end
            gcar = gg1[k] | (gp1[k] & gcar);
        end
        carry[WIDTH] = gcar;
        sum          = p1 ^ carry[WIDTH-1:0];
    end

    // Stage 1 register: capture G/P/GG/GP and carry-in on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            g1  <= '0;
            p1  <= '0;
            gg1 <= '0;
            gp1 <= '0;
            c1  <= 1'b0;
        end else if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
                g1  <= g_in;
                p1  <= p_in;
                gg1 <= gg_in;
                gp1 <= gp_in;
                c1  <= in;
            end
        end
    end

    // Stage 2 register: result holds while out_valid is high and out_ready is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            S    <= '0;
            cout <= 1'b0;
`ifdef CLA_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                S    <= sum;
                cout <= carry[WIDTH];
`ifdef CLA_OVF_EN
                ovf  <= carry[WIDTH-1] ^ carry[WIDTH];
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard testbench for cla_pipe_adder (WIDTH=16).
// Driver pushes expected results on accept; a monitor pops on each delivery.
module tb_cla_pipe_adder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s_out;
    logic         cout;
`ifdef CLA_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int last_waits = 0;
    exp_t sb[$];

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in        (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s_out),
        .cout      (cout)
`ifdef CLA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Offer one operand set starting at a negedge; returns at a negedge after acceptance
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] es, input logic ec, input logic eo);
        int  n    = 0;
        bit  done = 0;
        exp_t e;
        e.s = es; e.c = ec; e.o = eo;
        in_valid = 1'b1;
        a = av; b = bv; cin = cv;
        while (!done && n < 50) begin
            #1;
            if (in_ready) begin
                sb.push_back(e);
                done = 1;
            end else begin
                n++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid   = 1'b0;
        last_waits = n;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        logic [W:0] r;
        logic       o;
        r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        o = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
        send(av, bv, cv, r[W-1:0], r[W], o);
    endtask

    // Monitor: pops and compares whenever a result is delivered on the next edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", {16'd0, s_out}, {16'd0, e.s});
                    chk("cout", {31'd0, cout}, {31'd0, e.c});
`ifdef CLA_OVF_EN
                    chk("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_S", {16'd0, s_out}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Basic add, accepted on the first edge after reset release; 2-cycle latency
        send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        chk("first_accept_wait", last_waits, 32'd0);
        #1 chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1 chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_cycle2_S", {16'd0, s_out}, 32'h5555);
        @(negedge clk);

        // Directed carry/overflow corners
        send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        send(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        send(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // Backpressure: two accepts fill the pipe, then in_ready drops and S holds
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0, 1'b0);
        send(16'h1000, 16'h2000, 1'b1, 16'h3001, 1'b0, 1'b0);
        in_valid = 1'b1; a = 16'hF000; b = 16'h1000; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_S_hold", {16'd0, s_out}, 32'h0303);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0);
        send(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("bp_drained", sb.size(), 32'd0);

        // Streaming: back-to-back accepts with out_ready high
        begin
            int stalls = 0;
            for (int i = 0; i < 100; i++) begin
                send_model(W'($urandom), W'($urandom), 1'($urandom));
                stalls += last_waits;
            end
            chk("stream_no_stall", stalls, 32'd0);
        end
        repeat (4) @(negedge clk);
        chk("stream_drained", sb.size(), 32'd0);

        // Reset mid-stream with two results in flight
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        send(16'h4444, 16'h5555, 1'b0, 16'h9999, 1'b0, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_S", {16'd0, s_out}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end

        // Pipeline usable again after reset
        send(16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("final_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/sum width; legal values are multiples of 4 from 4 to 32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an operand set is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts the operand set this cycle.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, meaning the addends.
REQ-007 The block SHALL have port in, input, 1, meaning the carry-in.
REQ-008 The block SHALL have port out_valid, output, 1, meaning S/cout hold a result.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-010 The block SHALL have port S, output, WIDTH, meaning the registered sum.
REQ-011 The block SHALL have port cout, output, 1, meaning the registered carry-out.
REQ-012 The block SHALL have port ovf, output, 1, meaning signed overflow; it exists only under CLA_OVF_EN (REQ-028).

Function
REQ-013 The block SHALL accept a transfer when in_valid and in_ready are both high on a rising edge, and deliver one when out_valid and out_ready are both high.
REQ-014 Stage 1 SHALL register per-bit G=a&b and P=a^b, 4-bit group GG/GP, and in, plus a stage-1 valid flag v1.
REQ-015 Stage 2 SHALL compute group carries by lookahead from registered GG/GP and in, then bit carries within each group, then S=P^carry and cout, and register them with valid flag v2 (= out_valid).
REQ-016 Latency SHALL be exactly 2 cycles from the accept edge to out_valid high, with no stall.
REQ-017 Throughput SHALL be one result per cycle while out_ready stays high.
REQ-018 Stage 2 SHALL load when v2 is low or out_ready is high; stage 1 SHALL load when v1 is low or stage 2 loads.
REQ-019 in_ready SHALL equal (!v1 | !v2 | out_ready), purely combinational, with no dependency on in_valid.
REQ-020 While out_valid is high and out_ready is low, S, cout and ovf SHALL hold stable.
REQ-021 When both stages are full and out_ready is low, the block SHALL drop in_ready and lose no operand set.
REQ-022 Simultaneous accept and deliver in the same cycle SHALL be lossless, with the pipeline staying full.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH, with cout being bit WIDTH of a+b+in.
REQ-024 A stage whose valid flag is low SHALL be allowed to hold stale data; only out_valid qualifies S.

Reset
REQ-025 Asserting rst at any time SHALL immediately clear v1 and v2 and set out_valid=0, S=0, cout=0 and ovf=0.
REQ-026 Any in-flight operand sets SHALL be discarded on reset; in_ready SHALL read 1 while rst is held and after release.
REQ-027 The first accept after reset SHALL be possible on the first rising edge with rst low.

Configuration
REQ-028 With macro CLA_OVF_EN defined, port ovf SHALL be present and registered with S, equal to carry(WIDTH-1)^carry(WIDTH), and held under stall.
REQ-029 Without CLA_OVF_EN, port ovf and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Reset scenario: rst pulse mid-stream with two results in flight -> out_valid=0 and S=0 immediately; in_ready=1; no stale result emerges afterwards.
REQ-031 Basic add, WIDTH=16: a=16'h1234, b=16'h4321, in=0 accepted at cycle 0 -> S=16'h5555, cout=0, out_valid=1 at cycle 2.
REQ-032 Full carry ripple: a=16'hFFFF, b=16'h0000, in=1 -> S=16'h0000, cout=1; with CLA_OVF_EN, ovf=0; a=16'h7FFF, b=16'h0001, in=0 -> S=16'h8000, ovf=1.
REQ-033 Backpressure: stream 4 sets with out_ready=0 from cycle 1 -> in_ready drops after 2 accepts; releasing out_ready yields all 4 sums in order, none lost or duplicated.
REQ-034 Streaming: 100 random back-to-back sets with out_ready=1 -> one result per cycle matching a+b+in, and cout correct on every result.
